// File: rtl/fir_mac8.sv
// fir_mac8: eight-lane FIR multiply-accumulate sequencer feeding one rounded output per request.
// Optional FIR_MAC8_SAT_EN clamps the output instead of wrapping to DW bits.
module fir_mac8 #(
    parameter int ITER  = 64,
    parameter int DW    = 16,
    parameter int AW    = 8,
    parameter int ACC_W = 41,
    parameter int SHIFT = 15
) (
    input  logic          clk,
    input  logic          RSTN,
    input  logic          start,
    output logic          busy,
    output logic [AW-1:0] A,
    output logic          CEN,
    input  logic [DW-1:0] Q7, Q6, Q5, Q4, Q3, Q2, Q1, Q0,
    input  logic [DW-1:0] X7, X6, X5, X4, X3, X2, X1, X0,
    output logic [DW-1:0] Y,
    output logic          y_valid,
    input  logic          y_ready
);
    localparam int PW = 2 * DW;
    localparam int TW = PW + 3;
    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [ACC_W:0] YMAX = {{(ACC_W+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W:0] YMIN = {{(ACC_W+2-DW){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state_q;
    logic [AW-1:0]           a_q;
    logic                    cen_q;
    logic                    busy_q;
    logic                    yv_q;
    logic [DW-1:0]           y_q;
    logic [1:0]              drain_q;
    logic                    qv_q, pv_q, sv_q;
    logic signed [PW-1:0]    prod_q [8];
    logic signed [TW-1:0]    sum_q;
    logic signed [ACC_W-1:0] acc_q;

    logic signed [DW-1:0]    q_arr [8];
    logic signed [DW-1:0]    x_arr [8];
    logic signed [PW-1:0]    prod_d [8];
    logic signed [TW-1:0]    sum_d;
    logic signed [ACC_W:0]   shifted_d;
    logic [DW-1:0]           y_d;

    assign q_arr = '{Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7};
    assign x_arr = '{X0, X1, X2, X3, X4, X5, X6, X7};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign prod_d[gi] = q_arr[gi] * x_arr[gi];
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 8; i++) begin
            sum_d = sum_d + {{3{prod_q[i][PW-1]}}, prod_q[i]};
        end
    end

    // Round half up, then arithmetic shift down to Q15-scaled output.
    always_comb begin
        shifted_d = ({acc_q[ACC_W-1], acc_q} + RND) >>> SHIFT;
`ifdef FIR_MAC8_SAT_EN
        if (shifted_d > YMAX)
            y_d = DW'(YMAX);
        else if (shifted_d < YMIN)
            y_d = DW'(YMIN);
        else
            y_d = DW'(shifted_d);
`else
        y_d = DW'(shifted_d);
`endif
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            cen_q   <= 1'b1;
            busy_q  <= 1'b0;
            yv_q    <= 1'b0;
            y_q     <= '0;
            drain_q <= '0;
            qv_q    <= 1'b0;
            pv_q    <= 1'b0;
            sv_q    <= 1'b0;
            sum_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < 8; i++) prod_q[i] <= '0;
        end else begin
            // Valid bits follow the one-cycle memory latency through each stage.
            qv_q  <= ~cen_q;
            pv_q  <= qv_q;
            sv_q  <= pv_q;
            for (int i = 0; i < 8; i++) prod_q[i] <= prod_d[i];
            sum_q <= sum_d;
            if (sv_q)
                acc_q <= acc_q + {{(ACC_W-TW){sum_q[TW-1]}}, sum_q};

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        a_q     <= '0;
                        cen_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (a_q == AW'(ITER - 1)) begin
                        state_q <= S_DRAIN;
                        a_q     <= '0;
                        cen_q   <= 1'b1;
                        drain_q <= '0;
                    end else begin
                        a_q <= a_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == 2'd3) begin
                        state_q <= S_DONE;
                        y_q     <= y_d;
                        yv_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (y_ready) begin
                        state_q <= S_IDLE;
                        yv_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign A       = a_q;
    assign CEN     = cen_q;
    assign Y       = y_q;
    assign y_valid = yv_q;
endmodule
